// File: rtl/mips_run_ctrl.sv
// rtl/mips_run_ctrl.sv - run controller for the pipelined MIPS core.
// Sequences core reset, counts run cycles and retirements, and detects halt, stop and timeout.
module mips_run_ctrl #(
    parameter int RESET_CYCLES = 4,
    parameter int MAX_CYCLES   = 10000,
    parameter int HALT_REPEAT  = 3,
    parameter int PC_WIDTH     = 32,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 retire,
    input  logic [PC_WIDTH-1:0]  retire_pc,
    input  logic                 stop_req,
    output logic                 core_reset,
    output logic                 running,
    output logic                 done,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] retire_cnt
);

    localparam int HOLD_W = $clog2(RESET_CYCLES + 1) + 1;
    localparam int REP_W  = $clog2(HALT_REPEAT + 1);

    typedef enum logic [1:0] {
        S_HOLD,
        S_RUN,
        S_HALTED,
        S_TIMEOUT
    } state_t;

    state_t                state_q, state_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [CNT_WIDTH-1:0]  cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0]  retire_q, retire_d;
    logic [REP_W-1:0]      rep_q, rep_d;
    logic [PC_WIDTH-1:0]   last_pc_q, last_pc_d;
    logic                  core_reset_q, running_q, done_q, timeout_q;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cycle_d   = cycle_q;
        retire_d  = retire_q;
        rep_d     = rep_q;
        last_pc_d = last_pc_q;
        case (state_q)
            S_HOLD: begin
                if (hold_q == HOLD_W'(RESET_CYCLES)) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            S_RUN: begin
                cycle_d = cycle_q + CNT_WIDTH'(1);
                if (retire) begin
                    retire_d  = retire_q + CNT_WIDTH'(1);
                    // rep_q==0 marks "no retirement seen yet", so the reset value of last_pc never matches
                    if ((rep_q != '0) && (retire_pc == last_pc_q)) begin
                        rep_d = rep_q + REP_W'(1);
                    end else begin
                        rep_d = REP_W'(1);
                    end
                    last_pc_d = retire_pc;
                end
                if ((retire && (rep_d == REP_W'(HALT_REPEAT))) || stop_req) begin
                    state_d = S_HALTED;
                end else if (cycle_d == CNT_WIDTH'(MAX_CYCLES)) begin
                    state_d = S_TIMEOUT;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_HOLD;
            hold_q       <= '0;
            cycle_q      <= '0;
            retire_q     <= '0;
            rep_q        <= '0;
            last_pc_q    <= '0;
            core_reset_q <= 1'b1;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            cycle_q      <= cycle_d;
            retire_q     <= retire_d;
            rep_q        <= rep_d;
            last_pc_q    <= last_pc_d;
            core_reset_q <= (state_d == S_HOLD);
            running_q    <= (state_d == S_RUN);
            done_q       <= (state_d == S_HALTED) || (state_d == S_TIMEOUT);
            timeout_q    <= (state_d == S_TIMEOUT);
        end
    end

    assign core_reset = core_reset_q;
    assign running    = running_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign cycle_cnt  = cycle_q;
    assign retire_cnt = retire_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb/tb_mips_run_ctrl.sv - directed self-checking bench for mips_run_ctrl.
// Instance a: 4-cycle hold, 20-cycle budget; instance b: no hold, 6-cycle budget.
module tb_mips_run_ctrl;

    logic        clk = 1'b0;
    logic        reset_a, retire_a, stop_a;
    logic [31:0] pc_a;
    logic        core_reset_a, running_a, done_a, timeout_a;
    logic [31:0] cycle_a, retcnt_a;
    logic        reset_b, retire_b, stop_b;
    logic [31:0] pc_b;
    logic        core_reset_b, running_b, done_b, timeout_b;
    logic [31:0] cycle_b, retcnt_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mips_run_ctrl #(
        .RESET_CYCLES(4), .MAX_CYCLES(20), .HALT_REPEAT(3), .PC_WIDTH(32), .CNT_WIDTH(32)
    ) dut_a (
        .clk(clk), .reset(reset_a), .retire(retire_a), .retire_pc(pc_a), .stop_req(stop_a),
        .core_reset(core_reset_a), .running(running_a), .done(done_a), .timeout(timeout_a),
        .cycle_cnt(cycle_a), .retire_cnt(retcnt_a)
    );

    mips_run_ctrl #(
        .RESET_CYCLES(0), .MAX_CYCLES(6), .HALT_REPEAT(3), .PC_WIDTH(32), .CNT_WIDTH(32)
    ) dut_b (
        .clk(clk), .reset(reset_b), .retire(retire_b), .retire_pc(pc_b), .stop_req(stop_b),
        .core_reset(core_reset_b), .running(running_b), .done(done_b), .timeout(timeout_b),
        .cycle_cnt(cycle_b), .retire_cnt(retcnt_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic cr, input logic run, input logic dn,
                           input logic to, input logic [31:0] cyc, input logic [31:0] ret);
        check({tag, ".core_reset"}, {31'd0, core_reset_a}, {31'd0, cr});
        check({tag, ".running"}, {31'd0, running_a}, {31'd0, run});
        check({tag, ".done"}, {31'd0, done_a}, {31'd0, dn});
        check({tag, ".timeout"}, {31'd0, timeout_a}, {31'd0, to});
        check({tag, ".cycle_cnt"}, cycle_a, cyc);
        check({tag, ".retire_cnt"}, retcnt_a, ret);
    endtask

    task automatic retire_one(input logic [31:0] pc);
        retire_a = 1'b1;
        pc_a     = pc;
        tick();
        retire_a = 1'b0;
    endtask

    initial begin
        reset_a = 1'b1; retire_a = 1'b0; stop_a = 1'b0; pc_a = '0;
        reset_b = 1'b1; retire_b = 1'b0; stop_b = 1'b0; pc_b = '0;
        tick();
        tick();
        check_a("reset", 1, 0, 0, 0, 0, 0);

        // Reset sequencing: core_reset high through edge 4, RUN from edge 5
        reset_a = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("hold.core_reset", {31'd0, core_reset_a}, 32'd1);
            check("hold.running", {31'd0, running_a}, 32'd0);
        end
        tick();
        check_a("run_entry", 0, 1, 0, 0, 0, 0);

        // Halt on third consecutive retirement at the same PC
        retire_one(32'h3000);
        retire_one(32'h3004);
        retire_one(32'h3008);
        retire_one(32'h3008);
        check_a("pre_halt", 0, 1, 0, 0, 4, 4);
        retire_one(32'h3008);
        check_a("halt", 0, 0, 1, 0, 5, 5);
        for (int i = 0; i < 10; i++) begin
            retire_a = 1'b1;
            pc_a     = 32'h3008;
            tick();
        end
        retire_a = 1'b0;
        check_a("halt_frozen", 0, 0, 1, 0, 5, 5);

        // Async reset from a terminal state, then non-consecutive repeats and timeout
        #2 reset_a = 1'b1;
        #1 check_a("async_from_halt", 1, 0, 0, 0, 0, 0);
        reset_a = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_a("run_entry2", 0, 1, 0, 0, 0, 0);
        retire_one(32'h3008);
        retire_one(32'h300c);
        retire_one(32'h3008);
        retire_one(32'h3008);
        check_a("no_halt", 0, 1, 0, 0, 4, 4);
        for (int i = 0; i < 15; i++) tick();
        check_a("pre_timeout", 0, 1, 0, 0, 19, 4);
        tick();
        check_a("timeout", 0, 0, 1, 1, 20, 4);
        tick();
        tick();
        check_a("timeout_frozen", 0, 0, 1, 1, 20, 4);

        // Async reset mid-run at cycle_cnt=7, then stop_req held through HOLD
        #2 reset_a = 1'b1;
        #1 reset_a = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        retire_one(32'h100);
        for (int i = 0; i < 6; i++) tick();
        check_a("mid_run", 0, 1, 0, 0, 7, 1);
        #2 reset_a = 1'b1;
        #1 check_a("async_mid_run", 1, 0, 0, 0, 0, 0);
        stop_a = 1'b1;
        #1 reset_a = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_a("stop_in_hold", 1, 0, 0, 0, 0, 0);
        tick();
        check_a("stop_run_entry", 0, 1, 0, 0, 0, 0);
        tick();
        check_a("stop_halt", 0, 0, 1, 0, 1, 0);
        stop_a = 1'b0;

        // Instance b: zero hold cycles, third repeat coincides with the cycle budget
        reset_b = 1'b0;
        tick();
        check("b.core_reset_edge1", {31'd0, core_reset_b}, 32'd0);
        check("b.running_edge1", {31'd0, running_b}, 32'd1);
        tick();
        tick();
        tick();
        retire_b = 1'b1;
        pc_b     = 32'h40;
        tick();
        tick();
        check("b.pre_done", {31'd0, done_b}, 32'd0);
        tick();
        retire_b = 1'b0;
        check("b.done", {31'd0, done_b}, 32'd1);
        check("b.timeout", {31'd0, timeout_b}, 32'd0);
        check("b.running", {31'd0, running_b}, 32'd0);
        check("b.cycle_cnt", cycle_b, 32'd6);
        check("b.retire_cnt", retcnt_b, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
